// File: rtl/mspwm_pkg.sv
// Shared constants and types for the multi-channel shadow PWM.
// Config address map: 0=period, 1..NUM_CH=duty, NUM_CH+1=ctrl.
package mspwm_pkg;

   localparam int ADDR_PERIOD    = 0;
   localparam int ADDR_DUTY_BASE = 1;
   localparam int ADDR_CTRL_OFS  = 1;

   typedef enum logic {
      PWM_EDGE   = 1'b0,
      PWM_CENTER = 1'b1
   } pwm_mode_e;

   function automatic int ctrl_addr(input int num_ch);
      return num_ch + ADDR_CTRL_OFS;
   endfunction

endpackage

// File: rtl/mspwm_channel.sv
// One PWM channel: duty shadow/active pair and the output compare.
// The active duty only changes on the shared load strobe.
module mspwm_channel
   import mspwm_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_hit,
   input  logic [WIDTH-1:0] wdata,
   input  logic             load,
   input  logic [WIDTH-1:0] cnt_q,
   input  logic             en,
   output logic             pwm_out
);

   logic [WIDTH-1:0] duty_s;
   logic [WIDTH-1:0] duty_a;

   // Shadow takes CPU writes; active takes the shadow at a commit boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_s <= '0;
         duty_a <= '0;
      end else begin
         if (wr_hit) duty_s <= wdata;
         if (load)   duty_a <= duty_s;
      end
   end

   assign pwm_out = en & (cnt_q < duty_a);

endmodule

// File: rtl/multi_channel_shadow_pwm.sv
// Multi-channel PWM with shared counter and committed shadow registers.
// Optional center-aligned mode is built when PWM_CENTER_ALIGN_EN is defined.
module multi_channel_shadow_pwm
   import mspwm_pkg::*;
#(
   parameter  int WIDTH      = 8,
   parameter  int NUM_CH     = 4,
   parameter  int PERIOD_RST = 10,
   localparam int ADDR_W     = $clog2(NUM_CH + 2)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              cfg_wr,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [WIDTH-1:0]  cfg_wdata,
   input  logic              cfg_commit,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_start,
   output logic              upd_pending
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] PRST = WIDTH'(PERIOD_RST);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] period_s;
   logic [WIDTH-1:0] period_a;
   logic             pending_q;
   logic             wrap;
   logic             boundary;
   logic             apply;
   logic             per_hit;

   assign per_hit = cfg_wr && (cfg_addr == ADDR_W'(ADDR_PERIOD));

`ifdef PWM_CENTER_ALIGN_EN
   pwm_mode_e ctrl_s;
   pwm_mode_e ctrl_a;
   logic      dir_q;
   logic      dir_d;
   logic      ctrl_hit;

   assign ctrl_hit = cfg_wr &&
                     (cfg_addr == ADDR_W'(ctrl_addr(NUM_CH)));

   // Up/down stepping; period_a<=1 is identical to edge mode.
   always_comb begin
      cnt_d = cnt_q + ONE;
      dir_d = 1'b0;
      wrap  = (cnt_q == period_a);
      if (ctrl_a == PWM_CENTER && period_a > ONE) begin
         if (dir_q) begin
            cnt_d = cnt_q - ONE;
            dir_d = 1'b1;
            wrap  = (cnt_q <= ONE);
         end else begin
            wrap = 1'b0;
            if (cnt_q == period_a) begin
               cnt_d = cnt_q - ONE;
               dir_d = 1'b1;
            end
         end
      end
   end

   // Direction flop: 1 while counting down, forced up when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            dir_q <= 1'b0;
      else if (!en || wrap)  dir_q <= 1'b0;
      else                   dir_q <= dir_d;
   end

   // Mode shadow/active pair, committed like every other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_s <= PWM_EDGE;
         ctrl_a <= PWM_EDGE;
      end else begin
         if (ctrl_hit) ctrl_s <= pwm_mode_e'(cfg_wdata[0]);
         if (apply)    ctrl_a <= ctrl_s;
      end
   end
`else
   // Edge mode only: count up to period_a, then wrap.
   always_comb begin
      cnt_d = cnt_q + ONE;
      wrap  = (cnt_q == period_a);
   end
`endif

   // Idle counts as a boundary so a pending commit lands while stopped.
   assign boundary = ~en | wrap;
   assign apply    = boundary & (pending_q | cfg_commit);

   // Shared period counter, held at 0 while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            cnt_q <= '0;
      else if (!en || wrap)  cnt_q <= '0;
      else                   cnt_q <= cnt_d;
   end

   // Period shadow/active pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_s <= PRST;
         period_a <= PRST;
      end else begin
         if (per_hit) period_s <= cfg_wdata;
         if (apply)   period_a <= period_s;
      end
   end

   // Commit request held until the next boundary consumes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          pending_q <= 1'b0;
      else if (apply)      pending_q <= 1'b0;
      else if (cfg_commit) pending_q <= 1'b1;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      mspwm_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_hit  (cfg_wr &&
                   (cfg_addr == ADDR_W'(ADDR_DUTY_BASE + i))),
         .wdata   (cfg_wdata),
         .load    (apply),
         .cnt_q   (cnt_q),
         .en      (en),
         .pwm_out (pwm_out[i])
      );
   end

   assign period_start = en & (cnt_q == '0);
   assign upd_pending  = pending_q;

endmodule

// File: tb/tb_multi_channel_shadow_pwm.sv
// Directed bench for multi_channel_shadow_pwm (4 channels, 8-bit).
// Center-aligned checks run only when PWM_CENTER_ALIGN_EN is defined.
module tb_multi_channel_shadow_pwm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       cfg_wr;
   logic [2:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic       cfg_commit;
   logic [3:0] pwm_out;
   logic       period_start;
   logic       upd_pending;

   int n_chk  = 0;
   int n_fail = 0;

   multi_channel_shadow_pwm #(
      .WIDTH      (8),
      .NUM_CH     (4),
      .PERIOD_RST (10)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .cfg_wr       (cfg_wr),
      .cfg_addr     (cfg_addr),
      .cfg_wdata    (cfg_wdata),
      .cfg_commit   (cfg_commit),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .upd_pending  (upd_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at %0t",
                tag, obs, exp, $time);
      end
   endtask

   task automatic nc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      cfg_wr    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
   endtask

   // Edge-mode expectations: count c runs c0.. modulo plen.
   task automatic run(input string tag, input int n, input int c0,
                      input int plen, input int d0, input int d1,
                      input int d2, input int d3, input logic pend);
      for (int j = 0; j < n; j++) begin
         int c;
         logic [3:0] e;
         c = (c0 + j) % plen;
         e = {c < d3, c < d2, c < d1, c < d0};
         chk({tag, "/pwm"}, pwm_out, e);
         chk({tag, "/ps"}, period_start, c == 0);
         chk({tag, "/pend"}, upd_pending, pend);
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      en         = 1'b0;
      cfg_wr     = 1'b0;
      cfg_addr   = '0;
      cfg_wdata  = '0;
      cfg_commit = 1'b0;

      nc(2);
      chk("rst/pwm", pwm_out, 0);
      chk("rst/ps", period_start, 0);
      chk("rst/pend", upd_pending, 0);
      rst_n = 1'b1;
      nc(1);
      chk("idle/pwm", pwm_out, 0);
      chk("idle/ps", period_start, 0);

      en = 1'b1;
      #1;
      run("dflt", 22, 0, 11, 0, 0, 0, 0, 1'b0);

      wr(3'd0, 8'd9);   nc(1);
      wr(3'd1, 8'd3);   nc(1);
      wr(3'd2, 8'd10);  nc(1);
      cfg_wr = 1'b0;
      cfg_commit = 1'b1; nc(1);
      cfg_commit = 1'b0;
      run("wait1", 7, 4, 11, 0, 0, 0, 0, 1'b1);
      run("p9", 20, 0, 10, 3, 10, 0, 0, 1'b0);

      nc(4);
      wr(3'd1, 8'd5);  nc(1);
      cfg_wr = 1'b0;
      nc(5);
      run("nocmt", 30, 0, 10, 3, 10, 0, 0, 1'b0);
      nc(4);
      cfg_commit = 1'b1; nc(1);
      cfg_commit = 1'b0;
      run("cmt_wait", 5, 5, 10, 3, 10, 0, 0, 1'b1);
      run("d5", 10, 0, 10, 5, 10, 0, 0, 1'b0);

      nc(2);
      wr(3'd3, 8'd4);  nc(1);
      cfg_wr = 1'b0;
      nc(6);
      wr(3'd1, 8'd7);
      cfg_commit = 1'b1; nc(1);
      cfg_wr = 1'b0;
      cfg_commit = 1'b0;
      run("bnd_cmt", 10, 0, 10, 5, 10, 4, 0, 1'b0);
      cfg_commit = 1'b1; nc(1);
      cfg_commit = 1'b0;
      run("cmt2_wait", 9, 1, 10, 5, 10, 4, 0, 1'b1);
      run("d7", 10, 0, 10, 7, 10, 4, 0, 1'b0);

      wr(3'd1, 8'd2);  nc(1);
      cfg_wr = 1'b0;
      cfg_commit = 1'b1; nc(1);
      cfg_commit = 1'b0;
      chk("endrop/pend", upd_pending, 1);
      nc(1);
      en = 1'b0;
      #1;
      chk("endrop/pwm0", pwm_out, 0);
      nc(1);
      chk("idle_apply/pwm", pwm_out, 0);
      chk("idle_apply/ps", period_start, 0);
      chk("idle_apply/pend", upd_pending, 0);
      nc(2);
      en = 1'b1;
      #1;
      chk("reen/ps", period_start, 1);
      chk("reen/pwm", pwm_out, 4'b0111);
      run("reen", 10, 0, 10, 2, 10, 4, 0, 1'b0);

      nc(3);
      cfg_commit = 1'b1; nc(1);
      cfg_commit = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst/pwm", pwm_out, 0);
      chk("arst/pend", upd_pending, 0);
      chk("arst/ps_cnt0", period_start, 1);
      nc(1);
      rst_n = 1'b1;
      wr(3'd6, 8'd5);  nc(1);
      wr(3'd7, 8'd5);  nc(1);
      cfg_wr = 1'b0;
      cfg_commit = 1'b1; nc(1);
      cfg_commit = 1'b0;
      run("oor_wait", 8, 3, 11, 0, 0, 0, 0, 1'b1);
      run("oor", 11, 0, 11, 0, 0, 0, 0, 1'b0);

`ifdef PWM_CENTER_ALIGN_EN
      begin
         int cseq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
         wr(3'd5, 8'd1);  nc(1);
         wr(3'd0, 8'd4);  nc(1);
         wr(3'd1, 8'd2);  nc(1);
         cfg_wr = 1'b0;
         cfg_commit = 1'b1; nc(1);
         cfg_commit = 1'b0;
         run("ctr_wait", 7, 4, 11, 0, 0, 0, 0, 1'b1);
         for (int j = 0; j < 16; j++) begin
            int c;
            c = cseq[j % 8];
            chk("ctr/pwm", pwm_out, {3'b000, c < 2});
            chk("ctr/ps", period_start, c == 0);
            chk("ctr/pend", upd_pending, 0);
            @(negedge clk);
         end
         nc(2);
         rst_n = 1'b0;
         #1;
         chk("ctr_arst/pwm", pwm_out, 0);
         chk("ctr_arst/pend", upd_pending, 0);
         nc(1);
         rst_n = 1'b1;
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
